// File: rtl/stack_control_unit.sv
// stack_control_unit: accumulator CPU successor FSM with memory wait states,
// stack-depth tracking and sticky overflow/underflow/illegal-opcode traps.
`timescale 1ns/1ps
module stack_control_unit #(
  parameter int OPW = 8,
  parameter int STACK_DEPTH = 16,
  localparam int DW = $clog2(STACK_DEPTH + 1)
) (
  input  logic           CLK,
  input  logic           RESET_N,
  input  logic [OPW-1:0] opcode,
  input  logic           ZFLG,
  input  logic           NFLG,
  input  logic           MEM_RDY,
  output logic           FETCH,
  output logic           MEM_REQ,
  output logic           INC_PC,
  output logic           LOAD_PC,
  output logic           PC_SRC,
  output logic           LOAD_IRU,
  output logic           LOAD_IRL,
  output logic           LOAD_AC,
  output logic           STORE_MEM,
  output logic           WDATA_PC,
  output logic           SP_ADDR,
  output logic           LOAD_SP,
  output logic           SP_INC,
  output logic           SP_DEC,
  output logic [DW-1:0]  DEPTH,
  output logic           FAULT,
  output logic [1:0]     FAULT_CODE,
  output logic [4:0]     STATE
);
  typedef enum logic [4:0] {
    START, PREPU, FETCHU, EXEC1, PREPL, FETCHL, EXEC2, MEMRD, STORE, JUMP,
    LDSP, PUSH_DEC, PUSH_WR, POP_RD, JSR_DEC, JSR_WR, RTS_RD, TRAP
  } state_t;
  state_t state, next, dec;
  logic [1:0] trap_code;
  logic [4:0] cls;
  logic taken, full, empty;
  assign cls   = opcode[4:0];
  assign full  = DEPTH == DW'(STACK_DEPTH);
  assign empty = DEPTH == '0;
  assign STATE = state;
  assign taken = (opcode == OPW'('h10)) | ((opcode == OPW'('h11)) & NFLG) |
                 ((opcode == OPW'('h12)) & ~NFLG) | ((opcode == OPW'('h13)) & ZFLG) |
                 ((opcode == OPW'('h14)) & ~ZFLG);
  // Second-byte decode: ALU/memory classes use the low five bits, jump/stack ops the full opcode.
  always_comb begin
    dec = TRAP;
    case (cls)
      5'h02, 5'h06, 5'h08, 5'h0E, 5'h0F: dec = EXEC2;
      5'h01, 5'h05, 5'h07, 5'h09, 5'h0A, 5'h0B, 5'h0C, 5'h0D: dec = MEMRD;
      5'h03: dec = STORE;
      default: dec = TRAP;
    endcase
    if (opcode >= OPW'('h10) && opcode <= OPW'('h14)) dec = JUMP;
    if (opcode == OPW'('h15)) dec = LDSP;
    if (opcode == OPW'('h16)) dec = PUSH_DEC;
    if (opcode == OPW'('h17)) dec = POP_RD;
    if (opcode == OPW'('h18)) dec = JSR_DEC;
    if (opcode == OPW'('h19)) dec = RTS_RD;
  end
  always_comb begin
    next = state;
    trap_code = 2'b00;
    {FETCH, MEM_REQ, INC_PC, LOAD_PC, PC_SRC, LOAD_IRU, LOAD_IRL, LOAD_AC,
     STORE_MEM, WDATA_PC, SP_ADDR, LOAD_SP, SP_INC, SP_DEC} = '0;
    case (state)
      START: next = PREPU;
      PREPU, PREPL: begin
        FETCH = 1'b1;
        next = (state == PREPU) ? FETCHU : FETCHL;
      end
      FETCHU, FETCHL: begin
        FETCH = 1'b1;
        MEM_REQ = 1'b1;
        INC_PC = MEM_RDY;
        LOAD_IRU = MEM_RDY & (state == FETCHU);
        LOAD_IRL = MEM_RDY & (state == FETCHL);
        trap_code = (state == FETCHL && dec == TRAP) ? 2'b11 : 2'b00;
        if (MEM_RDY) next = (state == FETCHL) ? dec : (cls == 5'h00 || cls == 5'h04) ? EXEC1 : PREPL;
      end
      EXEC1, EXEC2: begin
        LOAD_AC = 1'b1;
        next = PREPU;
      end
      MEMRD: begin
        MEM_REQ = 1'b1;
        if (MEM_RDY) next = EXEC2;
      end
      STORE: begin
        MEM_REQ = 1'b1;
        STORE_MEM = MEM_RDY;
        if (MEM_RDY) next = PREPU;
      end
      JUMP: begin
        LOAD_PC = taken;
        next = PREPU;
      end
      LDSP: begin
        LOAD_SP = 1'b1;
        next = PREPU;
      end
      PUSH_DEC, JSR_DEC: begin
        SP_DEC = ~full;
        trap_code = full ? 2'b01 : 2'b00;
        next = full ? TRAP : (state == PUSH_DEC) ? PUSH_WR : JSR_WR;
      end
      PUSH_WR, JSR_WR: begin
        MEM_REQ = 1'b1;
        SP_ADDR = 1'b1;
        WDATA_PC = state == JSR_WR;
        STORE_MEM = MEM_RDY;
        LOAD_PC = MEM_RDY & (state == JSR_WR);
        if (MEM_RDY) next = PREPU;
      end
      POP_RD, RTS_RD: begin
        MEM_REQ = ~empty;
        SP_ADDR = ~empty;
        PC_SRC = ~empty & (state == RTS_RD);
        SP_INC = ~empty & MEM_RDY;
        LOAD_AC = ~empty & MEM_RDY & (state == POP_RD);
        LOAD_PC = ~empty & MEM_RDY & (state == RTS_RD);
        trap_code = empty ? 2'b10 : 2'b00;
        next = empty ? TRAP : MEM_RDY ? PREPU : state;
      end
      TRAP: next = TRAP;
      default: next = START;
    endcase
  end
  // Depth moves on the same edge that commits SP, so a trap always sees the pre-change value.
  always_ff @(negedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state <= START;
      DEPTH <= '0;
      FAULT <= 1'b0;
      FAULT_CODE <= 2'b00;
    end else begin
      state <= next;
      FAULT <= FAULT | (next == TRAP);
      if (next == TRAP && state != TRAP) FAULT_CODE <= trap_code;
      if (state == LDSP) DEPTH <= '0;
      else if (SP_DEC) DEPTH <= DEPTH + DW'(1);
      else if (SP_INC) DEPTH <= DEPTH - DW'(1);
    end
  end
endmodule

// File: tb/tb_stack_control_unit.sv
// tb_stack_control_unit: instruction-level behavioural model of the stack control unit,
// checked cycle by cycle plus directed literal expectations.
`timescale 1ns/1ps
module tb_stack_control_unit;
  localparam int SD = 16;
  localparam int DW = $clog2(SD + 1);
  localparam int F = 13, MR = 12, IPC = 11, LPC = 10, PSRC = 9, LIU = 8, LIL = 7;
  localparam int LAC = 6, SM = 5, WPC = 4, SPA = 3, LSP = 2, SPI = 1, SPD = 0;
  logic CLK, RESET_N, ZFLG, NFLG, MEM_RDY;
  logic [7:0] opcode;
  logic FETCH, MEM_REQ, INC_PC, LOAD_PC, PC_SRC, LOAD_IRU, LOAD_IRL, LOAD_AC;
  logic STORE_MEM, WDATA_PC, SP_ADDR, LOAD_SP, SP_INC, SP_DEC, FAULT;
  logic [DW-1:0] DEPTH;
  logic [1:0] FAULT_CODE;
  logic [4:0] STATE;
  logic [13:0] act;
  int checks = 0, errors = 0;
  string ph;
  int stk[$];
  bit mf;
  logic [1:0] mcode;
  int cnt_sreq, cnt_sm, cnt_spd, cnt_lpc, last_psrc;
  logic [7:0] legal [26] = '{8'h00, 8'h04, 8'h24, 8'h02, 8'h06, 8'h08, 8'h0E, 8'hEF, 8'h01, 8'h05,
                             8'h07, 8'h0B, 8'h03, 8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16,
                             8'h16, 8'h17, 8'h18, 8'h18, 8'h19, 8'h19};

  stack_control_unit #(.OPW(8), .STACK_DEPTH(SD)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .opcode(opcode), .ZFLG(ZFLG), .NFLG(NFLG), .MEM_RDY(MEM_RDY),
    .FETCH(FETCH), .MEM_REQ(MEM_REQ), .INC_PC(INC_PC), .LOAD_PC(LOAD_PC), .PC_SRC(PC_SRC),
    .LOAD_IRU(LOAD_IRU), .LOAD_IRL(LOAD_IRL), .LOAD_AC(LOAD_AC), .STORE_MEM(STORE_MEM),
    .WDATA_PC(WDATA_PC), .SP_ADDR(SP_ADDR), .LOAD_SP(LOAD_SP), .SP_INC(SP_INC), .SP_DEC(SP_DEC),
    .DEPTH(DEPTH), .FAULT(FAULT), .FAULT_CODE(FAULT_CODE), .STATE(STATE)
  );
  assign act = {FETCH, MEM_REQ, INC_PC, LOAD_PC, PC_SRC, LOAD_IRU, LOAD_IRL, LOAD_AC,
                STORE_MEM, WDATA_PC, SP_ADDR, LOAD_SP, SP_INC, SP_DEC};

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic string decode(input logic [7:0] o);
    int c, v;
    c = int'(o[4:0]);
    v = int'(o);
    if (c inside {2, 6, 8, 14, 15}) return "EXEC2";
    if (c inside {1, 5, 7} || (c >= 9 && c <= 13)) return "MEMRD";
    if (c == 3) return "STORE";
    if (v >= 16 && v <= 20) return "JUMP";
    if (v == 21) return "LDSP";
    if (v == 22) return "PUSH_DEC";
    if (v == 23) return "POP_RD";
    if (v == 24) return "JSR_DEC";
    if (v == 25) return "RTS_RD";
    return "TRAP";
  endfunction

  // Drive one cycle, compare DUT against the model, then advance the model.
  task automatic cycle(input logic [7:0] o, input bit r, input bit zz, input bit nn);
    logic [13:0] alw, wnt, e;
    bit mem, done, stk_mem;
    string aft;
    int op_stk;
    logic [1:0] tc;
    int v;
    @(posedge CLK);
    #1;
    opcode = o; MEM_RDY = r; ZFLG = zz; NFLG = nn;
    #2;
    alw = '0; wnt = '0; mem = 0; aft = ph; op_stk = 0; tc = 2'b00; v = int'(o);
    if (ph == "START") aft = "PREPU";
    else if (ph == "PREPU" || ph == "PREPL") begin
      alw[F] = 1; aft = (ph == "PREPU") ? "FETCHU" : "FETCHL";
    end else if (ph == "FETCHU") begin
      mem = 1; alw[F] = 1; wnt[IPC] = 1; wnt[LIU] = 1;
      aft = (o[4:0] == 5'd0 || o[4:0] == 5'd4) ? "EXEC1" : "PREPL";
    end else if (ph == "FETCHL") begin
      mem = 1; alw[F] = 1; wnt[IPC] = 1; wnt[LIL] = 1;
      aft = decode(o); tc = (aft == "TRAP") ? 2'b11 : 2'b00;
    end else if (ph == "EXEC1" || ph == "EXEC2") begin
      wnt[LAC] = 1; aft = "PREPU";
    end else if (ph == "MEMRD") begin
      mem = 1; aft = "EXEC2";
    end else if (ph == "STORE") begin
      mem = 1; wnt[SM] = 1; aft = "PREPU";
    end else if (ph == "JUMP") begin
      wnt[LPC] = (v == 16) || (v == 17 && nn) || (v == 18 && !nn) || (v == 19 && zz) || (v == 20 && !zz);
      aft = "PREPU";
    end else if (ph == "LDSP") begin
      wnt[LSP] = 1; op_stk = 3; aft = "PREPU";
    end else if (ph == "PUSH_DEC" || ph == "JSR_DEC") begin
      if (stk.size() == SD) begin aft = "TRAP"; tc = 2'b01; end
      else begin wnt[SPD] = 1; op_stk = 1; aft = (ph == "PUSH_DEC") ? "PUSH_WR" : "JSR_WR"; end
    end else if (ph == "PUSH_WR" || ph == "JSR_WR") begin
      mem = 1; alw[SPA] = 1; wnt[SM] = 1; aft = "PREPU";
      if (ph == "JSR_WR") begin alw[WPC] = 1; wnt[LPC] = 1; end
    end else if (ph == "POP_RD" || ph == "RTS_RD") begin
      if (stk.size() == 0) begin aft = "TRAP"; tc = 2'b10; end
      else begin
        mem = 1; alw[SPA] = 1; wnt[SPI] = 1; op_stk = 2; aft = "PREPU";
        if (ph == "POP_RD") wnt[LAC] = 1;
        else begin wnt[LPC] = 1; alw[PSRC] = 1; end
      end
    end
    done = !mem || r;
    e = alw | (done ? wnt : '0);
    e[MR] = mem;
    checks++;
    if (act !== e || int'(DEPTH) != stk.size() || FAULT !== mf || FAULT_CODE !== mcode) begin
      errors++;
      $display("FAIL cycle phase=%s op=%h rdy=%0d strobes=%b want %b depth=%0d want %0d fault=%b/%b want %b/%b",
               ph, o, r, act, e, DEPTH, stk.size(), FAULT, FAULT_CODE, mf, mcode);
    end
    stk_mem = (ph == "PUSH_WR" || ph == "JSR_WR" || ph == "POP_RD" || ph == "RTS_RD");
    if (stk_mem && MEM_REQ) cnt_sreq++;
    if (STORE_MEM) cnt_sm++;
    if (SP_DEC) cnt_spd++;
    if (LOAD_PC) begin cnt_lpc++; last_psrc = int'(PC_SRC); end
    if (done) begin
      if (op_stk == 1) stk.push_back(v);
      if (op_stk == 2) void'(stk.pop_back());
      if (op_stk == 3) stk.delete();
      if (aft == "TRAP" && ph != "TRAP") begin mf = 1; mcode = tc; end
      ph = aft;
    end
  endtask

  // Run one instruction from PREPU back to PREPU (or into TRAP); memory states wait `waits` cycles.
  task automatic instr(input logic [7:0] o, input int waits, input bit zz, input bit nn);
    int k, wc;
    string prev;
    cnt_sreq = 0; cnt_sm = 0; cnt_spd = 0; cnt_lpc = 0; last_psrc = -1;
    while (ph == "START") cycle(o, 1'b1, zz, nn);
    k = 0; wc = 0;
    do begin
      prev = ph;
      cycle(o, wc >= waits, zz, nn);
      wc = (ph == prev) ? wc + 1 : 0;
      k++;
    end while (ph != "PREPU" && ph != "TRAP" && k < 100);
    if (k >= 100) begin
      checks++; errors++;
      $display("FAIL instr_timeout op=%h phase=%s got no return required PREPU", o, ph);
    end
  endtask

  task automatic lit(input string name, input int a, input int e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, a, e);
    end
  endtask

  task automatic settle();
    @(negedge CLK);
    #1;
  endtask

  // Reset lands mid-cycle, so the check before the next negedge also proves it is asynchronous.
  task automatic do_reset();
    @(posedge CLK);
    #1;
    RESET_N = 1'b0; MEM_RDY = 1'b0;
    #2;
    checks++;
    if (act !== '0 || STATE !== 5'd0 || DEPTH !== '0 || FAULT !== 1'b0 || FAULT_CODE !== 2'b00) begin
      errors++;
      $display("FAIL reset: strobes=%b state=%0d depth=%0d fault=%b code=%b required all zero",
               act, STATE, DEPTH, FAULT, FAULT_CODE);
    end
    @(negedge CLK);
    @(negedge CLK);
    #1;
    RESET_N = 1'b1;
    ph = "START"; stk.delete(); mf = 0; mcode = 2'b00;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1);
  end

  initial begin
    logic [7:0] o;
    RESET_N = 1'b0; opcode = 8'h00; ZFLG = 0; NFLG = 0; MEM_RDY = 0;
    ph = "START"; mf = 0; mcode = 2'b00;
    do_reset();
    repeat (3) cycle(8'h16, 1'b0, 1'b0, 1'b0);
    lit("in_fetchu_memreq", int'(MEM_REQ), 1);
    do_reset();
    instr(8'h16, 3, 0, 0);
    settle();
    lit("push_wait_memreq_cycles", cnt_sreq, 4);
    lit("push_store_once", cnt_sm, 1);
    lit("push_depth", int'(DEPTH), 1);
    instr(8'h15, 0, 0, 0);
    settle();
    lit("ldsp_clears_depth", int'(DEPTH), 0);
    repeat (SD) instr(8'h16, 0, 0, 0);
    settle();
    lit("depth_full", int'(DEPTH), SD);
    instr(8'h16, 0, 0, 0);
    settle();
    lit("overflow_code", int'(FAULT_CODE), 1);
    lit("overflow_fault", int'(FAULT), 1);
    lit("overflow_no_spdec", cnt_spd, 0);
    repeat (3) cycle(8'h00, 1'b1, 1'b1, 1'b1);
    do_reset();
    instr(8'h15, 0, 0, 0);
    instr(8'h17, 1, 0, 0);
    settle();
    lit("underflow_code", int'(FAULT_CODE), 2);
    lit("underflow_no_memreq", cnt_sreq, 0);
    do_reset();
    instr(8'h18, 1, 0, 0);
    settle();
    lit("jsr_loadpc", cnt_lpc, 1);
    lit("jsr_pcsrc", last_psrc, 0);
    lit("jsr_depth", int'(DEPTH), 1);
    instr(8'h19, 2, 0, 0);
    settle();
    lit("rts_loadpc", cnt_lpc, 1);
    lit("rts_pcsrc", last_psrc, 1);
    lit("rts_depth", int'(DEPTH), 0);
    instr(8'h1F, 0, 0, 0);
    settle();
    lit("illegal_code", int'(FAULT_CODE), 3);
    do_reset();
    instr(8'h13, 0, 0, 0);
    settle();
    lit("jz_not_taken", cnt_lpc, 0);
    lit("jz_no_fault", int'(FAULT), 0);
    instr(8'h13, 0, 1, 0);
    lit("jz_taken", cnt_lpc, 1);
    instr(8'h12, 0, 0, 1);
    lit("jpos_not_taken", cnt_lpc, 0);
    instr(8'h11, 0, 0, 1);
    lit("jneg_taken", cnt_lpc, 1);
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 59) == 0) do_reset();
      o = ($urandom_range(0, 9) == 0) ? 8'($urandom) : legal[$urandom_range(0, 25)];
      instr(o, $urandom_range(0, 2), 1'($urandom), 1'($urandom));
      if (ph == "TRAP") begin
        repeat (2) cycle(8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        do_reset();
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
